// File: rtl/serial_addsub_if.sv
// serial_addsub_if
// Request/result bundle for the digit-serial adder/subtractor.
//   start          : request a new operation (honoured only while busy=0)
//   A, B           : operands, captured with an accepted start
//   Cin, Sub       : carry/borrow-in and mode (0=add, 1=subtract), captured with start
//   busy           : operation in progress
//   done           : one-cycle result-valid pulse
//   Sum, Carry     : registered result and final carry-out (subtract: 1 = no borrow)
//   Overflow       : two's-complement signed overflow of the result
// master drives the request side, slave is the arithmetic unit.
interface serial_addsub_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             Cin;
  logic             Sub;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] Sum;
  logic             Carry;
  logic             Overflow;

  modport master (
    output start, A, B, Cin, Sub,
    input  busy, done, Sum, Carry, Overflow
  );

  modport slave (
    input  start, A, B, Cin, Sub,
    output busy, done, Sum, Carry, Overflow
  );
endinterface

// File: rtl/serial_addsub.sv
// serial_addsub
// Digit-serial two's-complement adder/subtractor. Each RUN cycle pushes DIGIT
// bits (LSB digit first) through a ripple of DIGIT full-adder cells, with the
// carry held in a register between digits. Subtraction is A + ~B + ~Cin.
// Ports:
//   clk  : clock, all state changes on the rising edge
//   rst  : synchronous active-high reset
//   bus  : serial_addsub_if slave (start/A/B/Cin/Sub in, busy/done/Sum/Carry/Overflow out)
// Timing: start accepted at edge 0 -> digits retired at edges 1..N, result and
// done=1 appear after edge N (N = WIDTH/DIGIT), busy=0 in the done cycle.
module serial_addsub #(
  parameter int WIDTH = 8,
  parameter int DIGIT = 1
) (
  input  logic            clk,
  input  logic            rst,
  serial_addsub_if.slave  bus
);

  if ((WIDTH < 2) || (WIDTH > 64) || (DIGIT < 1) || (DIGIT > WIDTH) ||
      ((WIDTH % DIGIT) != 0)) begin : g_bad_params
    $error("serial_addsub: WIDTH must be 2..64 and DIGIT must divide WIDTH");
  end

  localparam int N  = WIDTH / DIGIT;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t           state_q,    state_d;
  logic [WIDTH-1:0] a_q,        a_d;
  logic [WIDTH-1:0] b_q,        b_d;
  logic [WIDTH-1:0] acc_q,      acc_d;
  logic             carry_q,    carry_d;
  logic [CW-1:0]    cnt_q,      cnt_d;
  logic             done_q,     done_d;
  logic [WIDTH-1:0] sum_q,      sum_d;
  logic             cout_q,     cout_d;
  logic             ovf_q,      ovf_d;

  logic [DIGIT-1:0]       digit_sum;
  logic                   digit_cout;
  logic                   digit_cin_top;
  logic [WIDTH+DIGIT-1:0] acc_shift;

  // Ripple of DIGIT full-adder cells over the low digit of the operand
  // shift registers. digit_cin_top keeps the carry entering the top cell,
  // which on the last digit is the carry into the MSB (for Overflow).
  always_comb begin
    digit_sum     = '0;
    digit_cout    = carry_q;
    digit_cin_top = carry_q;
    for (int i = 0; i < DIGIT; i++) begin
      digit_cin_top = digit_cout;
      digit_sum[i]  = a_q[i] ^ b_q[i] ^ digit_cout;
      digit_cout    = (a_q[i] & b_q[i]) | (digit_cout & (a_q[i] ^ b_q[i]));
    end
  end

  // New digit enters the accumulator from the top, so after N digits the
  // first (least significant) digit has reached bit 0.
  assign acc_shift = {digit_sum, acc_q};

  // Next-state logic. B is stored pre-inverted and the borrow pre-inverted
  // in subtract mode so the datapath is always a plain adder.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    acc_d   = acc_q;
    carry_d = carry_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    sum_d   = sum_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          a_d     = bus.A;
          b_d     = bus.Sub ? ~bus.B : bus.B;
          carry_d = bus.Sub ? ~bus.Cin : bus.Cin;
          acc_d   = '0;
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        a_d     = a_q >> DIGIT;
        b_d     = b_q >> DIGIT;
        acc_d   = acc_shift[WIDTH+DIGIT-1:DIGIT];
        carry_d = digit_cout;
        cnt_d   = cnt_q + 1'b1;
        if (cnt_q == CW'(N - 1)) begin
          state_d = IDLE;
          done_d  = 1'b1;
          sum_d   = acc_shift[WIDTH+DIGIT-1:DIGIT];
          cout_d  = digit_cout;
          ovf_d   = digit_cout ^ digit_cin_top;
          carry_d = 1'b0;
          cnt_d   = '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and registered outputs; reset wins over everything, which also
  // discards an operation in flight without a done pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      done_q  <= 1'b0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
      carry_q <= carry_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
  end

  assign bus.busy     = (state_q == RUN);
  assign bus.done     = done_q;
  assign bus.Sum      = sum_q;
  assign bus.Carry    = cout_q;
  assign bus.Overflow = ovf_q;

endmodule
